csa_accum_ctrl: RTL and testbench

CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

---
 rtl/csa_accum_ctrl_if.sv | 25 ++
 rtl/csa_accum_ctrl.sv | 127 ++++++++++++
 tb/tb_csa_accum_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_ctrl_if.sv
// Handshake bundle for csa_accum_ctrl: operand stream in, resolved batch result out.
interface csa_accum_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Batch accumulator: operands are folded into a carry-save pair (S, C) with one
// 3:2 reduction per beat, so the per-beat path is a single full-adder level.
// The carry-propagate add is deferred to a 4-cycle, 8-bit-per-cycle resolve.
module csa_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  csa_accum_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      s_q, s_d;
  logic [31:0]      c_q, c_d;
  logic [31:0]      r_q, r_d;
  logic             cy_q, cy_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Presented result is kept apart from R/count so it stays frozen while the
  // next batch is being accumulated and resolved.
  logic [31:0]      sum_out_q, sum_out_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  logic             accept;
  logic [8:0]       chunk_sum;
  logic [4:0]       chunk_lsb;

  assign bus.in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_out_q;
  assign bus.out_count = cnt_out_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign chunk_lsb     = {k_q, 3'b000};

  // Next-state and datapath update for the current FSM state
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    r_d       = r_q;
    cy_d      = cy_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    cnt_out_d = cnt_out_q;
    chunk_sum = 9'd0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          s_d     = bus.in_data;
          c_d     = 32'd0;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          k_d     = 2'd0;
          cy_d    = 1'b0;
          state_d = bus.in_last ? RESOLVE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          s_d     = s_q ^ c_q ^ bus.in_data;
          // Majority shifted left; the carry out of bit 31 is dropped (mod 2^32).
          c_d     = ((s_q & c_q) | (s_q & bus.in_data) | (c_q & bus.in_data)) << 1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          k_d     = 2'd0;
          cy_d    = 1'b0;
          state_d = bus.in_last ? RESOLVE : ACC;
        end
      end
      RESOLVE: begin
        chunk_sum = {1'b0, s_q[chunk_lsb +: 8]} + {1'b0, c_q[chunk_lsb +: 8]}
                  + {8'd0, cy_q};
        r_d[chunk_lsb +: 8] = chunk_sum[7:0];
        cy_d = chunk_sum[8];
        k_d  = k_q + 2'd1;
        if (k_q == 2'd3) begin
          // Final carry is discarded; publish the resolved result.
          sum_out_d = {chunk_sum[7:0], r_q[23:0]};
          cnt_out_d = cnt_q;
          cy_d      = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; clr wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      s_q       <= 32'd0;
      c_q       <= 32'd0;
      r_q       <= 32'd0;
      cy_q      <= 1'b0;
      k_q       <= 2'd0;
      cnt_q     <= '0;
      sum_out_q <= 32'd0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      r_q       <= r_d;
      cy_q      <= cy_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      cnt_out_q <= cnt_out_d;
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: one task per scenario, inline checks.
module tb_csa_accum_ctrl;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  csa_accum_ctrl_if #(.CNT_W(8)) bus ();

  csa_accum_ctrl #(.CNT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat for exactly one edge; caller guarantees in_ready=1.
  task automatic send_beat(input logic [31:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Advance until out_valid is seen, bounded to 20 edges.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.in_valid = 1'b1;   // handshake offered alongside clr must be ignored
    bus.in_data  = 32'h1234_5678;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd0) begin failures++; $display("FAIL reset_out_sum got=%h want=00000000", bus.out_sum); end
    checks++; if (bus.out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count got=%0d want=0", bus.out_count); end
    // A further idle cycle must not produce a result from the beat seen under clr.
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (bus.out_count !== 8'd0) begin failures++; $display("FAIL reset_priority count got=%0d want=0", bus.out_count); end
    $display("reset: in_ready=%b out_valid=%b sum=%h count=%0d", bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count);
  endtask

  task automatic test_small_batch();
    bus.out_ready = 1'b1;
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b0);
    send_beat(32'h3, 1'b1);
    // Now one delta past the accepting edge of the last beat.
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== (e == 4)) begin
        failures++;
        $display("FAIL latency edge=%0d out_valid got=%b want=%b", e, bus.out_valid, (e == 4));
      end
    end
    checks++; if (bus.out_sum !== 32'h6) begin failures++; $display("FAIL small_sum got=%h want=00000006", bus.out_sum); end
    checks++; if (bus.out_count !== 8'd3) begin failures++; $display("FAIL small_count got=%0d want=3", bus.out_count); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL small_done_in_ready got=%b want=0", bus.in_ready); end
    $display("batch 1,2,3: sum=%h count=%0d", bus.out_sum, bus.out_count);
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL small_to_idle out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_sum !== 32'h6) begin failures++; $display("FAIL small_hold_idle got=%h want=00000006", bus.out_sum); end
  endtask

  task automatic test_single_beat();
    bit ok;
    bus.out_ready = 1'b1;
    send_beat(32'hDEAD_BEEF, 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout out_valid got=0 want=1"); end
    checks++; if (bus.out_sum !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_sum got=%h want=deadbeef", bus.out_sum); end
    checks++; if (bus.out_count !== 8'd1) begin failures++; $display("FAIL single_count got=%0d want=1", bus.out_count); end
    $display("single deadbeef: sum=%h count=%0d", bus.out_sum, bus.out_count);
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit ok;
    bus.out_ready = 1'b1;
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h8000_0001, 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout out_valid got=0 want=1"); end
    checks++; if (bus.out_sum !== 32'h0) begin failures++; $display("FAIL wrap_sum got=%h want=00000000", bus.out_sum); end
    checks++; if (bus.out_count !== 8'd4) begin failures++; $display("FAIL wrap_count got=%0d want=4", bus.out_count); end
    $display("wrap batch: sum=%h count=%0d", bus.out_sum, bus.out_count);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    send_beat(32'h00FF_00FF, 1'b0);
    send_beat(32'h00FF_00FF, 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout out_valid got=0 want=1"); end
    // Offer junk while stalled; it must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAA_5555;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 32'h01FE_01FE || bus.out_count !== 8'd2) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b sum=%h count=%0d want 1/0/01fe01fe/2",
                 i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_sum !== 32'h01FE_01FE) begin failures++; $display("FAIL bp_idle_sum got=%h want=01fe01fe", bus.out_sum); end
    $display("backpressure batch: sum=%h count=%0d", bus.out_sum, bus.out_count);
  endtask

  task automatic test_saturate();
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.in_last = 1'b1;   // in_last without in_valid must be ignored
        @(posedge clk); #1;
        bus.in_last = 1'b0;
      end
      send_beat(32'h1, (i == 299));
    end
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sat_timeout out_valid got=0 want=1"); end
    checks++; if (bus.out_sum !== 32'h0000_012C) begin failures++; $display("FAIL sat_sum got=%h want=0000012c", bus.out_sum); end
    checks++; if (bus.out_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d want=255", bus.out_count); end
    $display("300 x 1: sum=%h count=%0d", bus.out_sum, bus.out_count);
    @(posedge clk); #1;
  endtask

  task automatic test_clr_mid_resolve();
    bit ok;
    bit seen;
    bus.out_ready = 1'b1;
    send_beat(32'h7, 1'b0);
    send_beat(32'h9, 1'b1);
    // First RESOLVE cycle runs to the next edge; clr is sampled at the end of the second.
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clr_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd0) begin failures++; $display("FAIL clr_out_sum got=%h want=00000000", bus.out_sum); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin failures++; $display("FAIL clr_abort partial result out_valid got=1 want=0"); end
    send_beat(32'h5, 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL clr_next_timeout out_valid got=0 want=1"); end
    checks++; if (bus.out_sum !== 32'h5) begin failures++; $display("FAIL clr_next_sum got=%h want=00000005", bus.out_sum); end
    checks++; if (bus.out_count !== 8'd1) begin failures++; $display("FAIL clr_next_count got=%0d want=1", bus.out_count); end
    $display("after clr abort, batch 5: sum=%h count=%0d", bus.out_sum, bus.out_count);
    @(posedge clk); #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    clr           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_small_batch();
    test_single_beat();
    test_wrap();
    test_backpressure();
    test_saturate();
    test_clr_mid_resolve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
